// File: rtl/ct_spsram_512x22_ctrl_pkg.sv
// Shared constants for the 512x22 single-port SRAM requester controller.
package ct_spsram_512x22_ctrl_pkg;

  localparam int unsigned SRAM_AW        = 9;
  localparam int unsigned SRAM_DW        = 22;
  localparam int unsigned SRAM_DEPTH     = 512;
  localparam int unsigned RSP_FIFO_DEPTH = 4;

  // Active-low SRAM pin encodings
  localparam logic CEN_ON  = 1'b0;
  localparam logic CEN_OFF = 1'b1;
  localparam logic GWEN_WR = 1'b0;
  localparam logic GWEN_RD = 1'b1;
  localparam logic WEN_OFF = 1'b1;
  localparam logic [SRAM_DW-1:0] WEN_ALL_OFF = {SRAM_DW{WEN_OFF}};

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } ctrl_state_t;

endpackage

// File: rtl/ct_spsram_512x22_ctrl_rsp_fifo.sv
// Small synchronous response FIFO holding captured read data in order.
module ct_spsram_ctrl_rsp_fifo
  import ct_spsram_512x22_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = RSP_FIFO_DEPTH,
  parameter int unsigned WIDTH = SRAM_DW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic                        do_push;
  logic                        do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and occupancy; simultaneous push and pop keep count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ct_spsram_512x22_ctrl.sv
// Requester-side controller for a 512x22 single-port SRAM: zero-fills the
// array after reset, then turns valid/ready requests into registered SRAM
// cycles and returns read data in order through a credit-limited FIFO.
module ct_spsram_512x22_ctrl
  import ct_spsram_512x22_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = SRAM_AW,
  parameter int unsigned           DATA_WIDTH = SRAM_DW,
  parameter int unsigned           DEPTH      = SRAM_DEPTH,
  parameter int unsigned           RSP_DEPTH  = RSP_FIFO_DEPTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bwe,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int unsigned CNT_W  = $clog2(RSP_DEPTH+1);
  localparam int unsigned CRED_W = $clog2(RSP_DEPTH+3);

  ctrl_state_t           state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
  logic                  cen_nx, gwen_nx;
  logic [DATA_WIDTH-1:0] wen_nx, d_nx;
  logic [ADDR_WIDTH-1:0] a_nx;
  logic                  rd_issue, rd_s1, rd_s2;
  logic                  req_acc, rsp_pop;
  logic                  rsp_full, rsp_empty;
  logic [CNT_W-1:0]      rsp_count;
  logic [CRED_W-1:0]     credits;

  // Every outstanding read owns a FIFO slot from issue until pop, so the
  // FIFO cannot overflow while credits stay below RSP_DEPTH.
  assign credits = CRED_W'(rd_s1) + CRED_W'(rd_s2) + CRED_W'(rsp_count);
  // init_done doubles as the "in RUN for at least one cycle" flag, which
  // keeps req_rdy low through the cycle that drives the last init write.
  assign req_rdy = init_done && (credits < CRED_W'(RSP_DEPTH));
  assign req_acc = req_vld && req_rdy;
  assign rsp_vld = !rsp_empty;
  assign rsp_pop = rsp_vld && rsp_rdy;

  // State and init address counter
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state and next SRAM pin values
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cen_nx   = CEN_OFF;
    gwen_nx  = GWEN_RD;
    wen_nx   = {DATA_WIDTH{WEN_OFF}};
    a_nx     = sram_a;
    d_nx     = sram_d;
    rd_issue = 1'b0;
    case (state)
      ST_INIT: begin
        cen_nx  = CEN_ON;
        gwen_nx = GWEN_WR;
        wen_nx  = '0;
        a_nx    = cnt;
        d_nx    = INIT_VALUE;
        cnt_nx  = cnt + 1'b1;
        if (cnt == ADDR_WIDTH'(DEPTH-1)) begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (req_acc) begin
          cen_nx = CEN_ON;
          a_nx   = req_addr;
          if (req_wen) begin
            gwen_nx = GWEN_WR;
            wen_nx  = ~req_bwe;
            d_nx    = req_wdata;
          end else begin
            rd_issue = 1'b1;
          end
        end
      end
    endcase
  end

  // Registered SRAM pins, read pipeline tracking and init_done
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      sram_cen  <= CEN_OFF;
      sram_gwen <= GWEN_RD;
      sram_wen  <= {DATA_WIDTH{WEN_OFF}};
      sram_a    <= '0;
      sram_d    <= '0;
      rd_s1     <= 1'b0;
      rd_s2     <= 1'b0;
      init_done <= 1'b0;
    end else begin
      sram_cen  <= cen_nx;
      sram_gwen <= gwen_nx;
      sram_wen  <= wen_nx;
      sram_a    <= a_nx;
      sram_d    <= d_nx;
      rd_s1     <= rd_issue;
      rd_s2     <= rd_s1;
      init_done <= (state == ST_RUN);
    end
  end

  ct_spsram_ctrl_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk   (forever_cpuclk),
    .rst   (cpurst),
    .push  (rd_s2),
    .wdata (sram_q),
    .pop   (rsp_pop),
    .rdata (rsp_rdata),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  rsp_overflow_a: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
    !(rd_s2 && rsp_full && !rsp_pop));

endmodule

// File: tb/tb_ct_spsram_512x22_ctrl.sv
// Self-checking bench for ct_spsram_512x22_ctrl with a behavioural SRAM and
// a transaction-level reference memory plus expected-response queue.
module tb_ct_spsram_512x22_ctrl;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        req_vld, req_rdy, req_wen;
  logic [8:0]  req_addr;
  logic [21:0] req_wdata, req_bwe;
  logic        rsp_vld, rsp_rdy;
  logic [21:0] rsp_rdata;
  logic        init_done;
  logic        sram_cen, sram_gwen;
  logic [21:0] sram_wen, sram_d, sram_q;
  logic [8:0]  sram_a;

  int n_checks = 0;
  int n_errors = 0;

  logic [21:0] smem    [512];
  logic [21:0] ref_mem [512];
  logic [21:0] expq [$];
  logic [21:0] obs_q [$];
  logic        hold;
  logic [21:0] hold_data;
  logic        acc_now;

  always #5 clk = ~clk;

  ct_spsram_512x22_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wen        (req_wen),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_bwe        (req_bwe),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_rdata      (rsp_rdata),
    .init_done      (init_done),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_a         (sram_a),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural SRAM: active-low controls, per-bit write mask, registered q
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) smem[sram_a] <= (smem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= smem[sram_a];
    end
  end

  // Transaction-level reference: memory contents and in-order read results
  always @(negedge clk) begin
    if (cpurst) begin
      expq.delete();
      for (int i = 0; i < 512; i++) ref_mem[i] = '0;
      hold    = 1'b0;
      acc_now = 1'b0;
    end else begin
      if (hold) check("rsp_stable", {rsp_vld, rsp_rdata}, {1'b1, hold_data});
      if (expq.size() == 0) check("no_stale_rsp", rsp_vld, 1'b0);
      if (rsp_vld && rsp_rdy && expq.size() > 0) begin
        check("rsp_data", rsp_rdata, expq.pop_front());
        obs_q.push_back(rsp_rdata);
      end
      acc_now = req_vld && req_rdy;
      if (acc_now) begin
        if (req_wen) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_bwe) | (req_wdata & req_bwe);
        else         expq.push_back(ref_mem[req_addr]);
      end
      hold      = rsp_vld && !rsp_rdy;
      hold_data = rsp_rdata;
    end
  end

  task automatic check_reset_pins();
    check("rst_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
          {1'b1, 1'b1, 22'h3FFFFF, 9'h0, 22'h0});
    check("rst_ctl", {req_rdy, rsp_vld, rsp_rdata, init_done}, {1'b0, 1'b0, 22'h0, 1'b0});
  endtask

  // Called at posedge+1 right after reset release
  task automatic check_init();
    logic [8:0] ai;
    @(negedge clk);
    check("init_first_idle", {sram_cen, req_rdy}, {1'b1, 1'b0});
    for (int i = 0; i < 512; i++) begin
      ai = 9'(i);
      @(negedge clk);
      check("init_pins", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d, req_rdy, init_done},
            {1'b0, 1'b0, 22'h0, ai, 22'h0, 1'b0, 1'b0});
    end
    @(negedge clk);
    check("init_done", {init_done, req_rdy, sram_cen, sram_gwen, sram_wen},
          {1'b1, 1'b1, 1'b1, 1'b1, 22'h3FFFFF});
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle after the accept edge
  task automatic do_req(input logic w, input logic [8:0] ad, input logic [21:0] wd,
                        input logic [21:0] bw);
    logic ok;
    req_vld = 1'b1; req_wen = w; req_addr = ad; req_wdata = wd; req_bwe = bw;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_rdy) begin ok = 1'b1; break; end
    end
    check("req_accept", ok, 1'b1);
    @(posedge clk); #1;
    req_vld = 1'b0;
    @(negedge clk);
    check("pin_ctl", {sram_cen, sram_gwen, sram_wen, sram_a},
          {1'b0, !w, (w ? ~bw : 22'h3FFFFF), ad});
    if (w) check("pin_d", sram_d, wd);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (expq.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain", expq.size(), 0);
  endtask

  initial begin
    cpurst = 1'b0; req_vld = 1'b0; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0; req_bwe = '0; rsp_rdy = 1'b0;
    #1 cpurst = 1'b1;
    #2 check_reset_pins();
    repeat (2) @(posedge clk);
    #1 cpurst = 1'b0;

    // 1: full-array init sequence
    check_init();

    // 2: write then read back, response two clocks after read accept
    rsp_rdy = 1'b0;
    do_req(1'b1, 9'h1A5, 22'h2AAAAA, 22'h3FFFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_write_rsp", rsp_vld, 1'b0);
    end
    @(posedge clk); #1;
    do_req(1'b0, 9'h1A5, '0, '0);
    @(negedge clk);
    check("rd_lat_e1", rsp_vld, 1'b0);
    @(negedge clk);
    check("rd_lat_e2", {rsp_vld, rsp_rdata}, {1'b1, 22'h2AAAAA});
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    drain();

    // 3: partial write with bit mask
    obs_q.delete();
    do_req(1'b1, 9'h003, 22'h3FFFFF, 22'h0007FF);
    do_req(1'b0, 9'h003, '0, '0);
    drain();
    check("partial_rd", (obs_q.size() == 1) ? obs_q[0] : 22'h3DEAD, 22'h0007FF);

    // 4: credit limit with stalled responses
    for (int k = 0; k < 4; k++) do_req(1'b1, 9'h40 + 9'(k), 22'h0ABC0 | 22'(k), 22'h3FFFFF);
    drain();
    obs_q.delete();
    begin
      int n_acc;
      n_acc = 0;
      rsp_rdy = 1'b0; req_vld = 1'b1; req_wen = 1'b0; req_addr = 9'h40;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (req_rdy) n_acc++;
        @(posedge clk); #1;
        if (n_acc < 6) req_addr = 9'h40 + 9'(n_acc);
      end
      check("t4_accepts", n_acc, 4);
      @(negedge clk);
      check("t4_rdy_low", req_rdy, 1'b0);
      @(posedge clk); #1;
      req_vld = 1'b0; rsp_rdy = 1'b1;
      @(negedge clk);
      check("t4_rdy_hold", req_rdy, 1'b0);
      @(negedge clk);
      check("t4_rdy_rise", req_rdy, 1'b1);
      @(posedge clk); #1;
      drain();
      check("t4_nrsp", obs_q.size(), 4);
      for (int k = 0; k < 4; k++)
        check("t4_order", (k < obs_q.size()) ? obs_q[k] : 22'h3DEAD, 22'h0ABC0 | 22'(k));
    end

    // 5: reset with reads in flight and queued
    rsp_rdy = 1'b0; req_vld = 1'b1; req_wen = 1'b0; req_addr = 9'h40;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_rdy", req_rdy, 1'b1);
      @(posedge clk); #1;
      req_addr = req_addr + 1'b1;
    end
    req_vld = 1'b0;
    @(negedge clk);
    check("t5_queued", rsp_vld, 1'b1);
    #1 cpurst = 1'b1;
    #1 check_reset_pins();
    @(posedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    cpurst = 1'b0; rsp_rdy = 1'b1;
    check_init();

    // 6: back-to-back read / write / read on one address
    obs_q.delete();
    rsp_rdy = 1'b1; req_vld = 1'b1; req_wen = 1'b0; req_addr = 9'h1FF;
    req_wdata = 22'h155555; req_bwe = 22'h3FFFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_b2b_rdy", req_rdy, 1'b1);
      @(posedge clk); #1;
      req_wen = (k == 0);
    end
    req_vld = 1'b0;
    drain();
    check("t6_nrsp", obs_q.size(), 2);
    check("t6_old", (obs_q.size() > 0) ? obs_q[0] : 22'h3DEAD, 22'h000000);
    check("t6_new", (obs_q.size() > 1) ? obs_q[1] : 22'h3DEAD, 22'h155555);

    // Randomised traffic on a small address window
    for (int c = 0; c < 600; c++) begin
      rsp_rdy = ($urandom_range(0, 3) != 0);
      if (!req_vld || acc_now) begin
        req_vld   = ($urandom_range(0, 3) != 0);
        req_wen   = 1'($urandom_range(0, 1));
        req_addr  = 9'($urandom_range(0, 15));
        req_wdata = 22'($urandom);
        case ($urandom_range(0, 2))
          0:       req_bwe = 22'h3FFFFF;
          1:       req_bwe = 22'h0;
          default: req_bwe = 22'($urandom);
        endcase
      end
      @(posedge clk); #1;
    end
    req_vld = 1'b0; rsp_rdy = 1'b1;
    @(posedge clk); #1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ct_spsram_512x22_ctrl.md
Name: ct_spsram_512x22_ctrl

Overview:
- Requester-side controller driving the pins of a 512x22 single-port SRAM with active-low CEN/GWEN/WEN.
- Converts a valid/ready request channel and a valid/ready response channel into legal SRAM cycles.
- Captures read data, buffers responses in order, and zero-initialises the whole array after reset.
- Sits between cache/tag logic and the SRAM wrapper.

Parameters:
ADDR_WIDTH, 9, SRAM address width
DATA_WIDTH, 22, SRAM data and write-mask width
DEPTH, 512, number of entries initialised after reset
RSP_DEPTH, 4, response FIFO entries; also the read credit limit
INIT_VALUE, 22'h0, data written to every entry during init

Ports:
forever_cpuclk  in   1   single clock
cpurst          in   1   asynchronous reset, active-high
req_vld         in   1   request valid
req_rdy         out  1   request ready
req_wen         in   1   1 = write, 0 = read
req_addr        in   9   request address
req_wdata       in   22  write data
req_bwe         in   22  active-high bit write enable
rsp_vld         out  1   read response valid
rsp_rdy         in   1   response ready
rsp_rdata       out  22  read data
init_done       out  1   initialisation complete
sram_cen        out  1   SRAM chip enable, active-low
sram_gwen       out  1   SRAM global write enable, active-low
sram_wen        out  22  SRAM bit write enable, active-low
sram_a          out  9   SRAM address
sram_d          out  22  SRAM write data
sram_q          in   22  SRAM read data

Behaviour:
- Clock and reset: single clock forever_cpuclk; cpurst is asynchronous, active-high.
- Reset values: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0, req_rdy=0, rsp_vld=0, rsp_rdata=0, init_done=0. All SRAM pin outputs are registered.
- FSM states: INIT, RUN.
  - Reset forces INIT with init counter = 0.
  - INIT, per cycle: cen=0, gwen=0, wen=0, a=counter, d=INIT_VALUE; counter increments.
  - After the address DEPTH-1 write is issued, go to RUN; init_done=1 from the next cycle and stays 1 until reset.
- Request handshake: req_rdy = (state==RUN) && (credits < RSP_DEPTH).
  - credits = reads in pipeline stages S1/S2 plus FIFO occupancy.
  - req_rdy does not depend on req_vld or req_wen.
  - A write consumes no credit but is gated by the same req_rdy.
- Accept edge E0 (req_vld && req_rdy): pin registers load.
  - Read: cen=0, gwen=1, wen=all 1.
  - Write: cen=0, gwen=0, wen=~req_bwe, d=req_wdata.
  - A write with req_bwe=0 is legal and modifies nothing.
- No accept: cen=1, gwen=1, wen=all 1; a and d hold their previous values.
- SRAM samples the pins at E1. For reads, sram_q is captured into the FIFO at E2, so rsp_vld is visible no earlier than 2 clocks after E0.
- Sustained throughput: one request per cycle with rsp_rdy held at 1.
- Responses are strictly in request order. A read after a write to the same address returns the new data, since SRAM accesses are sequential.
- FIFO pop: on rsp_vld && rsp_rdy.
  - Push and pop in the same cycle are allowed, with occupancy unchanged.
  - A credit is freed on pop, so req_rdy may rise the next cycle.
  - rsp_rdata/rsp_vld are stable while rsp_vld && !rsp_rdy.
- Overflow is impossible by construction; an overflow assertion is required.
- Reset mid-operation: in-flight reads and FIFO contents are discarded, no stale response is emitted, and init restarts at address 0.
- Requests presented during INIT stall (req_rdy=0); they are never dropped.

Decomposition:
- Shared constants header: ADDR/DATA widths, DEPTH, RSP_DEPTH, and the active-low pin encodings (CEN_ON=0, GWEN_WR=0, WEN_ALL_OFF=all 1).
- One sub-module: ct_spsram_ctrl_rsp_fifo, a synchronous RSP_DEPTH x DATA_WIDTH FIFO with push/pop/full/empty/count and the same async active-high reset.

Test Plan:
1. Release cpurst → 512 consecutive cycles with cen=0, gwen=0, wen=0, a=0..511, d=0; req_rdy=0 throughout; init_done=1 on the cycle after a=511; idle pins afterwards.
2. After init: write addr 0x1A5, data 0x2AAAAA, bwe=0x3FFFFF, then read 0x1A5 → rsp_vld two clocks after the read accept, rsp_rdata=0x2AAAAA; no response for the write.
3. Partial write to addr 3: data 0x3FFFFF, bwe=0x0007FF → sram_wen=0x3FF800; a subsequent read returns 0x0007FF.
4. Hold rsp_rdy=0 and offer 6 back-to-back reads → exactly 4 accepted, req_rdy=0 thereafter. Raise rsp_rdy → 4 in-order responses; req_rdy returns 1 the cycle after the first pop.
5. Two reads in flight plus one queued, then assert cpurst for 1 cycle → pins return to reset values immediately, rsp_vld=0, init restarts at a=0, and no old data ever appears on rsp.
6. rsp_rdy=1 with stream: read 511, write 511=0x155555, read 511 on consecutive cycles → all accepted back-to-back; responses 0x000000 then 0x155555.
